// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into saturating nstep values for the difftest control stage.
// Optional emit statistics ports are enabled by defining DIFFTEST_STEP_BATCH_STATS_EN.
module difftest_step_batcher #(
  parameter int STEP_W  = 8,
  parameter int CNT_W   = 4,
  parameter int ACC_W   = 16,
  parameter int BATCH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              commit_valid,
  input  logic [CNT_W-1:0]  commit_cnt,
  input  logic              flush,
  input  logic              simv_result,
  output logic [STEP_W-1:0] step,
  output logic [ACC_W-1:0]  pending,
  output logic              halted,
  output logic              acc_overflow
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
  ,
  output logic [31:0]       emit_count,
  output logic [47:0]       step_total
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HALTED
  } state_e;

  // arithmetic width covers both the accumulator and step ranges plus a carry
  localparam int XW = ((ACC_W > STEP_W) ? ACC_W : STEP_W) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [XW-1:0] ACC_MAX  = XW'({ACC_W{1'b1}});
  localparam logic [XW-1:0] STEP_MAX = XW'({STEP_W{1'b1}});
  localparam logic [XW-1:0] BATCH_X  = XW'(BATCH);
  localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                fp_q, fp_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                ovf_q, ovf_d;
  logic                halted_q, halted_d;

  logic [XW-1:0]       inc;
  logic [XW-1:0]       sum;
  logic [XW-1:0]       sat;
  logic [XW-1:0]       e;
  logic [XW-1:0]       rem;
  logic                ovf_hit;
  logic                nz;
  logic                emit;
  logic                emit_ok;

  always_comb begin
    inc     = commit_valid ? XW'(commit_cnt) : '0;
    sum     = XW'(acc_q) + inc;
    ovf_hit = sum > ACC_MAX;
    sat     = ovf_hit ? ACC_MAX : sum;
    e       = (sat > STEP_MAX) ? STEP_MAX : sat;
    rem     = sat - e;
    nz      = sat != '0;
    emit    = nz && ((sat >= BATCH_X) || (timer_q == TLAST) ||
                     flush || fp_q);
    emit_ok = emit && (state_q != HALTED) && !simv_result;

    state_d  = state_q;
    acc_d    = acc_q;
    timer_d  = timer_q;
    fp_d     = fp_q;
    step_d   = '0;
    ovf_d    = ovf_q;

    if (state_q == HALTED) begin
      acc_d   = '0;
      timer_d = '0;
      fp_d    = 1'b0;
    end else if (simv_result) begin
      // halt wins over any emit; this cycle's commits are dropped
      state_d = HALTED;
      acc_d   = '0;
      timer_d = '0;
      fp_d    = 1'b0;
    end else begin
      ovf_d = ovf_q | ovf_hit;
      if (emit) begin
        step_d  = STEP_W'(e);
        acc_d   = ACC_W'(rem);
        timer_d = '0;
      end else begin
        acc_d   = ACC_W'(sat);
        timer_d = nz ? timer_q + TW'(1) : '0;
      end
      fp_d    = (flush || fp_q) && (acc_d != '0);
      state_d = (acc_d != '0) ? ACCUM : IDLE;
    end

    halted_d = state_d == HALTED;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      timer_q  <= '0;
      fp_q     <= 1'b0;
      step_q   <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      timer_q  <= timer_d;
      fp_q     <= fp_d;
      step_q   <= step_d;
      ovf_q    <= ovf_d;
      halted_q <= halted_d;
    end
  end

  assign step         = step_q;
  assign pending      = acc_q;
  assign halted       = halted_q;
  assign acc_overflow = ovf_q;

`ifdef DIFFTEST_STEP_BATCH_STATS_EN
  logic [31:0] emit_cnt_q, emit_cnt_d;
  logic [47:0] step_tot_q, step_tot_d;

  always_comb begin
    emit_cnt_d = emit_cnt_q;
    step_tot_d = step_tot_q;
    if (emit_ok) begin
      emit_cnt_d = emit_cnt_q + 32'd1;
      step_tot_d = step_tot_q + 48'(e);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      emit_cnt_q <= '0;
      step_tot_q <= '0;
    end else begin
      emit_cnt_q <= emit_cnt_d;
      step_tot_q <= step_tot_d;
    end
  end

  assign emit_count = emit_cnt_q;
  assign step_total = step_tot_q;
`else
  logic unused_emit_ok;
  assign unused_emit_ok = emit_ok;
`endif

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Scoreboard bench for difftest_step_batcher: three parameterisations,
// directed stimulus pushes expected emits, negedge monitors pop and compare.
module tb_difftest_step_batcher;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int step;
    int pend;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // u0: default parameters
  logic        r0, v0, f0, s0;
  logic [3:0]  c0;
  logic [7:0]  st0;
  logic [15:0] p0;
  logic        h0, o0;

  // u1: wide commit count, BATCH = STEP_MAX
  logic        r1, v1, f1, s1;
  logic [9:0]  c1;
  logic [7:0]  st1;
  logic [15:0] p1;
  logic        h1, o1;

  // u2: narrow accumulator that can saturate without emitting
  logic        r2, v2, f2, s2;
  logic [3:0]  c2;
  logic [8:0]  st2;
  logic [7:0]  p2;
  logic        h2, o2;

  difftest_step_batcher u0 (
    .clock(clock), .reset(r0), .commit_valid(v0), .commit_cnt(c0),
    .flush(f0), .simv_result(s0), .step(st0), .pending(p0),
    .halted(h0), .acc_overflow(o0)
  );

  difftest_step_batcher #(
    .CNT_W(10), .BATCH(255)
  ) u1 (
    .clock(clock), .reset(r1), .commit_valid(v1), .commit_cnt(c1),
    .flush(f1), .simv_result(s1), .step(st1), .pending(p1),
    .halted(h1), .acc_overflow(o1)
  );

  difftest_step_batcher #(
    .STEP_W(9), .ACC_W(8), .BATCH(300), .TIMEOUT(1000)
  ) u2 (
    .clock(clock), .reset(r2), .commit_valid(v2), .commit_cnt(c2),
    .flush(f2), .simv_result(s2), .step(st2), .pending(p2),
    .halted(h2), .acc_overflow(o2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_emit(input string n, input int st, input int p,
                          input exp_t e);
    checks++;
    if (st != e.step || p != e.pend || cyc != e.cyc) begin
      errors++;
      $display("FAIL %s emit: got step %0d pending %0d cycle %0d expected step %0d pending %0d cycle %0d",
               n, st, p, cyc, e.step, e.pend, e.cyc);
    end
  endtask

  task automatic stray(input string n, input int st);
    checks++;
    errors++;
    $display("FAIL %s stray step: got %0d expected 0 at cycle %0d",
             n, st, cyc);
  endtask

  always @(negedge clock) begin
    if (st0 != 0) begin
      if (q0.size() == 0) stray("u0", int'(st0));
      else cmp_emit("u0", int'(st0), int'(p0), q0.pop_front());
    end
    if (st1 != 0) begin
      if (q1.size() == 0) stray("u1", int'(st1));
      else cmp_emit("u1", int'(st1), int'(p1), q1.pop_front());
    end
    if (st2 != 0) begin
      if (q2.size() == 0) stray("u2", int'(st2));
      else cmp_emit("u2", int'(st2), int'(p2), q2.pop_front());
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    v0 = 0; f0 = 0; s0 = 0; c0 = '0;
    v1 = 0; f1 = 0; s1 = 0; c1 = '0;
    v2 = 0; f2 = 0; s2 = 0; c2 = '0;
    tick;
    tick;
    chk("reset step", int'(st0), 0);
    chk("reset pending", int'(p0), 0);
    chk("reset halted", int'(h0), 0);
    chk("reset overflow", int'(o0), 0);
    chk("reset u2 overflow", int'(o2), 0);
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
    tick;

    // threshold: 4 x 8 reaches BATCH=32
    for (int i = 0; i < 4; i++) begin
      v0 = 1; c0 = 4'd8;
      if (i == 3) q0.push_back('{32, 0, cyc + 1});
      tick;
      if (i == 1) chk("thr acc", int'(p0), 16);
    end
    v0 = 0;
    chk("thr pending", int'(p0), 0);
    tick;
    chk("thr step clear", int'(st0), 0);

    // burst of 15s crosses the threshold at 45
    for (int i = 0; i < 3; i++) begin
      v0 = 1; c0 = 4'd15;
      if (i == 2) q0.push_back('{45, 0, cyc + 1});
      tick;
      if (i == 1) chk("burst acc", int'(p0), 30);
    end
    v0 = 0;
    tick;
    chk("burst pending", int'(p0), 0);

    // flush emits a small accumulator including same-cycle commits
    v0 = 1; c0 = 4'd4;
    tick;
    chk("flush pre", int'(p0), 4);
    c0 = 4'd2; f0 = 1;
    q0.push_back('{6, 0, cyc + 1});
    tick;
    v0 = 0; f0 = 0;
    chk("flush post", int'(p0), 0);
    tick;

    // timeout: single commit of 3 emitted 63 cycles after its edge
    v0 = 1; c0 = 4'd3;
    q0.push_back('{3, 0, cyc + 64});
    tick;
    v0 = 0;
    repeat (30) tick;
    chk("timeout wait", int'(p0), 3);
    repeat (40) tick;
    chk("timeout done", int'(p0), 0);

    // timer restarts for the next lone commit
    v0 = 1; c0 = 4'd5;
    q0.push_back('{5, 0, cyc + 64});
    tick;
    v0 = 0;
    repeat (70) tick;
    chk("timeout2 done", int'(p0), 0);

    // halt priority: acc=31 then commit 1 with simv_result
    v0 = 1; c0 = 4'd15;
    tick;
    tick;
    c0 = 4'd1;
    tick;
    chk("halt pre", int'(p0), 31);
    s0 = 1; c0 = 4'd1;
    tick;
    s0 = 0;
    chk("halt flag", int'(h0), 1);
    chk("halt pending", int'(p0), 0);
    chk("halt step", int'(st0), 0);
    c0 = 4'd8; f0 = 1;
    repeat (6) tick;
    v0 = 0; f0 = 0;
    chk("halted pending", int'(p0), 0);
    chk("halted sticky", int'(h0), 1);

    // saturating drain: 600 with flush -> 255, 255, 90
    v1 = 1; c1 = 10'd600; f1 = 1;
    q1.push_back('{255, 345, cyc + 1});
    q1.push_back('{255, 90, cyc + 2});
    q1.push_back('{90, 0, cyc + 3});
    tick;
    v1 = 0; f1 = 0;
    repeat (4) tick;
    chk("drain pending", int'(p1), 0);

    // drain absorbs commits that arrive mid-drain
    v1 = 1; c1 = 10'd600; f1 = 1;
    q1.push_back('{255, 345, cyc + 1});
    q1.push_back('{255, 190, cyc + 2});
    q1.push_back('{190, 0, cyc + 3});
    tick;
    f1 = 0; c1 = 10'd100;
    tick;
    v1 = 0;
    repeat (4) tick;
    chk("drain2 pending", int'(p1), 0);

    // asynchronous reset mid-drain
    v1 = 1; c1 = 10'd600; f1 = 1;
    tick;
    v1 = 0; f1 = 0;
    chk("rst pre step", int'(st1), 255);
    #2;
    r1 = 1'b1;
    #1;
    chk("rst async step", int'(st1), 0);
    chk("rst async pending", int'(p1), 0);
    tick;
    r1 = 1'b0;
    tick;

    // threshold remainder stays below BATCH and leaves via timeout
    v1 = 1; c1 = 10'd300;
    q1.push_back('{255, 45, cyc + 1});
    q1.push_back('{45, 0, cyc + 65});
    tick;
    v1 = 0;
    chk("rem pending", int'(p1), 45);
    repeat (70) tick;
    chk("rem done", int'(p1), 0);

    // overflow: 18 x 15 saturates an 8-bit accumulator
    for (int i = 0; i < 18; i++) begin
      v2 = 1; c2 = 4'd15;
      tick;
      if (i == 16) begin
        chk("ovf at 255", int'(p2), 255);
        chk("ovf not yet", int'(o2), 0);
      end
    end
    v2 = 0;
    chk("ovf pending", int'(p2), 255);
    chk("ovf flag", int'(o2), 1);
    tick;
    f2 = 1;
    q2.push_back('{255, 0, cyc + 1});
    tick;
    f2 = 0;
    chk("ovf sticky1", int'(o2), 1);
    chk("ovf drained", int'(p2), 0);
    v2 = 1; c2 = 4'd7; f2 = 1;
    q2.push_back('{7, 0, cyc + 1});
    tick;
    v2 = 0; f2 = 0;
    tick;
    chk("ovf sticky2", int'(o2), 1);

    repeat (3) tick;
    chk("u0 queue empty", q0.size(), 0);
    chk("u1 queue empty", q1.size(), 0);
    chk("u2 queue empty", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
